// File: rtl/xy_state_counter.sv
// Up/down counter with an enable/direction FSM: one dead TURN cycle per
// direction reversal, wrap or saturate at 0 / MAX_COUNT.
module xy_state_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 9,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  input  logic             y,
  input  logic             clear,
  output logic [WIDTH-1:0] state,
  output logic [1:0]       mode,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    TURN = 2'b11
  } mode_t;

  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             inc, dec;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and count update
  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;

    if (clear) begin
      mode_d  = IDLE;
      count_d = '0;
    end else begin
      unique case (mode_q)
        IDLE: begin
          if (x) begin
            if (!y) begin
              mode_d = UP;
              inc    = 1'b1;
            end else begin
              mode_d = DOWN;
              dec    = 1'b1;
            end
          end
        end
        UP: begin
          if (!x)      mode_d = IDLE;
          else if (!y) inc    = 1'b1;
          else         mode_d = TURN;
        end
        DOWN: begin
          if (!x)     mode_d = IDLE;
          else if (y) dec    = 1'b1;
          else        mode_d = TURN;
        end
        TURN: begin
          if (!x) begin
            mode_d = IDLE;
          end else if (!y) begin
            mode_d = UP;
            inc    = 1'b1;
          end else begin
            mode_d = DOWN;
            dec    = 1'b1;
          end
        end
        default: mode_d = IDLE;
      endcase

      // Limit handling: wrap pulses only when the count actually rolls over
      if (inc) begin
        if (count_q >= MAX_VAL) begin
          if (SATURATE != 0) begin
            count_d = MAX_VAL;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else if (dec) begin
        if (count_q == '0) begin
          if (SATURATE == 0) begin
            count_d = MAX_VAL;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  assign state  = count_q;
  assign mode   = mode_q;
  assign wrap   = wrap_q;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_xy_state_counter.sv
// Directed bench for xy_state_counter: a wrapping instance driven from a
// vector table plus hand sequences, and a saturating instance.
module tb_xy_state_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       x = 1'b0, y = 1'b0, clear = 1'b0;
  logic [3:0] state;
  logic [1:0] mode;
  logic       at_max, at_min, wrap;

  logic       sx = 1'b0, sy = 1'b0, sclear = 1'b0;
  logic [3:0] s_state;
  logic [1:0] s_mode;
  logic       s_at_max, s_at_min, s_wrap;

  int compared = 0;
  int mismatched = 0;

  localparam logic [1:0] M_IDLE = 2'b00, M_UP = 2'b01, M_DOWN = 2'b10, M_TURN = 2'b11;

  xy_state_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u_dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .clear(clear),
    .state(state), .mode(mode), .at_max(at_max), .at_min(at_min), .wrap(wrap)
  );

  xy_state_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .x(sx), .y(sy), .clear(sclear),
    .state(s_state), .mode(s_mode), .at_max(s_at_max), .at_min(s_at_min), .wrap(s_wrap)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       clr;
    logic       x;
    logic       y;
    logic [3:0] st;
    logic [1:0] md;
    logic       wr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic xi, input logic yi,
                     input logic [3:0] st, input logic [1:0] md, input logic wr);
    vec_t v;
    v.clr = c; v.x = xi; v.y = yi; v.st = st; v.md = md; v.wr = wr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, need %0d", nm, got, exp);
    end
  endtask

  // Full check of the wrapping instance; at_max/at_min follow from the expected count
  task automatic chk_main(input string nm, input logic [3:0] st, input logic [1:0] md,
                          input logic wr);
    chk({nm, ".state"}, int'(state), int'(st));
    chk({nm, ".mode"}, int'(mode), int'(md));
    chk({nm, ".wrap"}, int'(wrap), int'(wr));
    chk({nm, ".at_max"}, int'(at_max), int'(st == 4'd9));
    chk({nm, ".at_min"}, int'(at_min), int'(st == 4'd0));
  endtask

  task automatic chk_sat(input string nm, input logic [3:0] st, input logic [1:0] md,
                         input logic wr);
    chk({nm, ".state"}, int'(s_state), int'(st));
    chk({nm, ".mode"}, int'(s_mode), int'(md));
    chk({nm, ".wrap"}, int'(s_wrap), int'(wr));
    chk({nm, ".at_max"}, int'(s_at_max), int'(st == 4'd9));
    chk({nm, ".at_min"}, int'(s_at_min), int'(st == 4'd0));
  endtask

  task automatic step(input logic c, input logic xi, input logic yi);
    clear = c; x = xi; y = yi;
    @(posedge clock);
    #1;
  endtask

  task automatic sstep(input logic c, input logic xi, input logic yi);
    sclear = c; sx = xi; sy = yi;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Up-wrap: 1..9 then 0 with a one-cycle wrap pulse
    for (int i = 1; i <= 9; i++) add(0, 1, 0, 4'(i), M_UP, 0);
    add(0, 1, 0, 4'd0, M_UP, 1);
    add(0, 1, 0, 4'd1, M_UP, 0);
    for (int i = 2; i <= 5; i++) add(0, 1, 0, 4'(i), M_UP, 0);
    // Reversal at 5
    add(0, 1, 1, 4'd5, M_TURN, 0);
    add(0, 1, 1, 4'd4, M_DOWN, 0);
    add(0, 1, 1, 4'd3, M_DOWN, 0);
    add(0, 0, 0, 4'd3, M_IDLE, 0);
    add(0, 0, 1, 4'd3, M_IDLE, 0);
    add(1, 1, 0, 4'd0, M_IDLE, 0);
    // Down-wrap from IDLE at 0
    add(0, 1, 1, 4'd9, M_DOWN, 1);
    add(0, 1, 1, 4'd8, M_DOWN, 0);
    add(0, 1, 0, 4'd8, M_TURN, 0);
    add(0, 1, 0, 4'd9, M_UP, 0);
    // Clear beats an up-count at MAX: no wrap
    add(1, 1, 0, 4'd0, M_IDLE, 0);
    add(0, 1, 0, 4'd1, M_UP, 0);
    add(0, 1, 1, 4'd1, M_TURN, 0);
    add(0, 0, 0, 4'd1, M_IDLE, 0);
    add(0, 1, 0, 4'd2, M_UP, 0);
    add(0, 0, 0, 4'd2, M_IDLE, 0);
    add(0, 1, 1, 4'd1, M_DOWN, 0);
    add(0, 0, 1, 4'd1, M_IDLE, 0);
    add(0, 1, 1, 4'd0, M_DOWN, 0);
    add(0, 1, 0, 4'd0, M_TURN, 0);
    add(0, 1, 1, 4'd9, M_DOWN, 1);
    add(0, 1, 1, 4'd8, M_DOWN, 0);

    #12;
    chk_main("reset_hold", 4'd0, M_IDLE, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].x, vecs[i].y);
      chk_main($sformatf("vec%0d", i), vecs[i].st, vecs[i].md, vecs[i].wr);
    end

    // Async reset mid-count at 6 in UP
    step(1, 0, 0);
    for (int i = 1; i <= 6; i++) step(0, 1, 0);
    chk_main("pre_areset", 4'd6, M_UP, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_main("areset_now", 4'd0, M_IDLE, 0);
    x = 1'b1; y = 1'b0; clear = 1'b0;
    @(posedge clock);
    #1;
    chk_main("areset_held", 4'd0, M_IDLE, 0);
    @(negedge clock);
    reset = 1'b1;
    step(0, 1, 0);
    chk_main("after_release", 4'd1, M_UP, 0);

    // Async reset while in TURN
    step(0, 1, 1);
    chk_main("turn_pre", 4'd1, M_TURN, 0);
    #3;
    reset = 1'b0;
    #1;
    chk_main("turn_areset", 4'd0, M_IDLE, 0);
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0);

    // Saturating instance: up from 8 holds at 9, down at 0 holds at 0
    sstep(1, 0, 0);
    for (int i = 1; i <= 8; i++) sstep(0, 1, 0);
    chk_sat("sat_at8", 4'd8, M_UP, 0);
    for (int i = 0; i < 3; i++) begin
      sstep(0, 1, 0);
      chk_sat($sformatf("sat_up%0d", i), 4'd9, M_UP, 0);
    end
    sstep(1, 0, 0);
    chk_sat("sat_clear", 4'd0, M_IDLE, 0);
    for (int i = 0; i < 2; i++) begin
      sstep(0, 1, 1);
      chk_sat($sformatf("sat_dn%0d", i), 4'd0, M_DOWN, 0);
    end
    sstep(0, 1, 0);
    chk_sat("sat_turn", 4'd0, M_TURN, 0);
    sstep(0, 1, 0);
    chk_sat("sat_up_after", 4'd1, M_UP, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xy_state_counter.md
XY_STATE_COUNTER -- requirements
Module: xy_state_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the count register width in bits.
REQ-002 The block SHALL have parameter MAX_COUNT, default 9, meaning the terminal count value, legal range 1 to 2**WIDTH-1.
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 0 = wrap at the count limits and 1 = hold at the count limits.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port x, input, 1 bit: count enable.
REQ-007 The block SHALL have port y, input, 1 bit: direction request, 0 = up and 1 = down.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous clear.
REQ-009 The block SHALL have port state, output, WIDTH bits: the registered count value.
REQ-010 The block SHALL have port mode, output, 2 bits: the registered FSM state, encoded IDLE=00, UP=01, DOWN=10, TURN=11.
REQ-011 The block SHALL have port at_max, output, 1 bit, defined as state==MAX_COUNT, decoded combinationally from the register.
REQ-012 The block SHALL have port at_min, output, 1 bit, defined as state==0, decoded combinationally from the register.
REQ-013 The block SHALL have port wrap, output, 1 bit: a registered one-cycle pulse marking a count wrap-around.

Function
REQ-014 clear=1 at a rising edge SHALL force state=0, mode=IDLE and wrap=0, taking priority over x and y.
REQ-015 IDLE: x=0 SHALL hold; x=1,y=0 SHALL go to UP and increment on the same edge; x=1,y=1 SHALL go to DOWN and decrement on the same edge.
REQ-016 UP: x=0 SHALL go to IDLE with no count; x=1,y=0 SHALL stay in UP and increment; x=1,y=1 SHALL go to TURN with no count.
REQ-017 DOWN: x=0 SHALL go to IDLE with no count; x=1,y=1 SHALL stay in DOWN and decrement; x=1,y=0 SHALL go to TURN with no count.
REQ-018 TURN (one dead cycle per direction reversal): x=0 SHALL go to IDLE; x=1,y=0 SHALL go to UP and increment; x=1,y=1 SHALL go to DOWN and decrement.
REQ-019 Increment at state==MAX_COUNT: with SATURATE=0, state SHALL become 0 and wrap SHALL be 1 for the following cycle; with SATURATE=1, state SHALL hold MAX_COUNT and wrap SHALL stay 0.
REQ-020 Decrement at state==0: with SATURATE=0, state SHALL become MAX_COUNT and wrap SHALL pulse; with SATURATE=1, state SHALL hold 0 and wrap SHALL stay 0.
REQ-021 Away from the limits, the count SHALL change by exactly 1 per counting edge.
REQ-022 state SHALL never exceed MAX_COUNT.
REQ-023 wrap SHALL be 0 on every edge that does not wrap, including consecutive non-wrapping counts.
REQ-024 Latency: state, mode and wrap SHALL reflect inputs sampled at edge N immediately after edge N, with no additional pipeline stage.
REQ-025 at_max and at_min SHALL track state with no register delay.

Reset
REQ-026 reset=0 SHALL immediately, without a clock edge, force state=0, mode=IDLE and wrap=0, including in the middle of counting or in TURN.
REQ-027 While reset=0, all outputs SHALL hold their reset values regardless of clock, x, y and clear.
REQ-028 The first rising edge after reset returns to 1 SHALL be evaluated normally from IDLE.

Verification (WIDTH=4, MAX_COUNT=9 unless stated)
REQ-029 Up-wrap: from reset, x=1,y=0 for 10 edges -> state 1..9 with mode=UP and at_max=1 at 9; the 10th edge gives state=0, wrap=1 for one cycle, at_min=1.
REQ-030 Reversal: in UP at state=5, y changes to 1 with x=1 -> edge 1: mode=TURN, state=5; edge 2: mode=DOWN, state=4; edge 3: state=3.
REQ-031 Down-wrap: from IDLE at state=0, x=1,y=1 for one edge -> state=9, mode=DOWN, wrap=1 for one cycle.
REQ-032 Saturate (SATURATE=1): up from 8 for 3 edges -> state 9,9,9 with wrap always 0; down from 0 -> state stays 0 with wrap 0.
REQ-033 Async reset: reset is driven to 0 between clock edges while counting at state=6 in UP -> state=0, mode=IDLE and wrap=0 before the next edge; after release, x=1,y=0 gives state=1 on the first edge.
REQ-034 Clear priority: clear=1 with x=1,y=0 at state=9 -> state=0, mode=IDLE, wrap=0 with no wrap pulse.
